// File: rtl/control_sequencer_pkg.sv
// cpu_pkg: shared opcodes, sequencer state encoding, instruction field positions
// and the opcode legality check for the 16-bit, 16-register CPU.
package cpu_pkg;

    localparam logic [3:0] OP_SETC = 4'h0;
    localparam logic [3:0] OP_COPY = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_NEG  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_SHL1 = 4'h8;
    localparam logic [3:0] OP_GT   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_HALTED
    } seqState_t;

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int DST_HI  = 11;
    localparam int DST_LO  = 8;
    localparam int SRCA_HI = 7;
    localparam int SRCA_LO = 4;
    localparam int SRCB_HI = 3;
    localparam int SRCB_LO = 0;
    localparam int IMM_HI  = 7;
    localparam int IMM_LO  = 0;

    function automatic logic isLegalOpcode(input logic [3:0] op);
        return op inside {OP_SETC, OP_COPY, OP_ADD, OP_NEG, OP_AND, OP_OR, OP_SHL1, OP_GT, OP_HALT};
    endfunction

endpackage

// File: rtl/control_sequencer_decoder.sv
// instruction_decoder: combinational opcode classification.
// Ports: opcode in; legal, writesReg, immSelect, isHalt out.
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       legal,
    output logic       writesReg,
    output logic       immSelect,
    output logic       isHalt
);

    assign legal     = isLegalOpcode(opcode);
    assign isHalt    = opcode == OP_HALT;
    assign writesReg = legal && !isHalt;
    assign immSelect = opcode == OP_SETC;

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller.
// Ports: clk, reset (sync, active-high), start, programSel in; instruction in from memory;
// address/programSelect to memory; regReadA/B, regWriteEn/Addr, aluOp, immSelect, immediate
// to the datapath; busy, done, illegalOp, overrun, instrCount status.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        programSel,
    input  logic [15:0]       instruction,
    output logic [ADDR_W-1:0] address,
    output logic [1:0]        programSelect,
    output logic [3:0]        regReadA,
    output logic [3:0]        regReadB,
    output logic              regWriteEn,
    output logic [3:0]        regWriteAddr,
    output logic [3:0]        aluOp,
    output logic              immSelect,
    output logic [7:0]        immediate,
    output logic              busy,
    output logic              done,
    output logic              illegalOp,
    output logic              overrun,
    output logic [7:0]        instrCount
);

    seqState_t         state, nextState;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic              decLegal, decWrites, decImm, decHalt;
    logic              lastPc;

    instruction_decoder decoder (
        .opcode   (ir[OPC_HI:OPC_LO]),
        .legal    (decLegal),
        .writesReg(decWrites),
        .immSelect(decImm),
        .isHalt   (decHalt)
    );

    assign lastPc     = pc == ADDR_W'(MEM_DEPTH - 1);
    assign address    = pc;
    assign regReadA   = ir[SRCA_HI:SRCA_LO];
    assign regReadB   = ir[SRCB_HI:SRCB_LO];
    assign immediate  = ir[IMM_HI:IMM_LO];
    assign regWriteEn = state == ST_EXECUTE && decWrites;
    assign busy       = state inside {ST_FETCH, ST_DECODE, ST_EXECUTE};
    assign done       = state == ST_HALTED;

    always_comb begin
        nextState = state;
        case (state)
            ST_IDLE, ST_HALTED: nextState = start ? ST_FETCH : state;
            ST_FETCH:           nextState = ST_DECODE;
            ST_DECODE:          nextState = decHalt ? ST_HALTED : ST_EXECUTE;
            ST_EXECUTE:         nextState = lastPc ? ST_HALTED : ST_FETCH;
            default:            nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    // Write-side controls are registered when leaving DECODE so they stay
    // stable through EXECUTE and keep their last values in HALTED.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= '0;
            ir            <= '0;
            programSelect <= '0;
            instrCount    <= '0;
            illegalOp     <= 1'b0;
            overrun       <= 1'b0;
            regWriteAddr  <= '0;
            aluOp         <= '0;
            immSelect     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALTED: begin
                    if (start) begin
                        programSelect <= programSel;
                        pc            <= '0;
                        instrCount    <= '0;
                        illegalOp     <= 1'b0;
                        overrun       <= 1'b0;
                    end
                end
                ST_FETCH: ir <= instruction;
                ST_DECODE: begin
                    if (!decHalt) begin
                        regWriteAddr <= ir[DST_HI:DST_LO];
                        aluOp        <= ir[OPC_HI:OPC_LO];
                        immSelect    <= decImm && decLegal;
                    end
                end
                ST_EXECUTE: begin
                    if (instrCount != 8'hFF) instrCount <= instrCount + 8'd1;
                    if (!decLegal) illegalOp <= 1'b1;
                    if (lastPc) overrun <= 1'b1;
                    else        pc <= pc + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized scoreboard bench for control_sequencer against a
// program-level reference model.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  programSel = 2'b00;
    logic [15:0] instruction;
    logic [7:0]  address;
    logic [1:0]  programSelect;
    logic [3:0]  regReadA, regReadB, regWriteAddr, aluOp;
    logic        regWriteEn, immSelect, busy, done, illegalOp, overrun;
    logic [7:0]  immediate, instrCount;

    logic [15:0] mem [4][128];

    typedef struct {
        logic [3:0] addr;
        logic [3:0] op;
        logic       imm;
        logic [7:0] val;
    } wr_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] cnt;
        logic       ill;
        logic       ovr;
        int         cycles;
        logic [1:0] sel;
    } fin_t;

    wr_t  expW[$];
    fin_t expF[$];
    int   errors = 0;
    int   checks = 0;
    int   runCycles = 0;
    logic prevDone = 1'b0;
    wr_t  gotW;
    fin_t gotF;

    always #5 clk = ~clk;

    assign instruction = mem[programSelect][address[6:0]];

    control_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .programSel   (programSel),
        .instruction  (instruction),
        .address      (address),
        .programSelect(programSelect),
        .regReadA     (regReadA),
        .regReadB     (regReadB),
        .regWriteEn   (regWriteEn),
        .regWriteAddr (regWriteAddr),
        .aluOp        (aluOp),
        .immSelect    (immSelect),
        .immediate    (immediate),
        .busy         (busy),
        .done         (done),
        .illegalOp    (illegalOp),
        .overrun      (overrun),
        .instrCount   (instrCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Runs the program to completion at the instruction level and queues the
    // register writes and the final status it implies.
    task automatic model(input logic [1:0] sel);
        int   pc = 0;
        int   retired = 0;
        int   cycles = 0;
        logic ill = 1'b0;
        logic ovr = 1'b0;
        logic [15:0] w;
        wr_t  e;
        fin_t f;
        while (1) begin
            w = mem[sel][pc];
            if (w[15:12] == 4'hE) begin
                cycles += 2;
                break;
            end
            cycles += 3;
            retired++;
            if (w[15:12] inside {4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB}) begin
                e.addr = w[11:8];
                e.op   = w[15:12];
                e.imm  = w[15:12] == 4'h0;
                e.val  = w[7:0];
                expW.push_back(e);
            end else begin
                ill = 1'b1;
            end
            if (pc == 127) begin
                ovr = 1'b1;
                break;
            end
            pc++;
        end
        f.addr   = 8'(pc);
        f.cnt    = retired > 255 ? 8'hFF : 8'(retired);
        f.ill    = ill;
        f.ovr    = ovr;
        f.cycles = cycles;
        f.sel    = sel;
        expF.push_back(f);
    endtask

    task automatic launch(input logic [1:0] sel, input bit hold);
        model(sel);
        programSel = sel;
        start = 1'b1;
        if (!hold) begin
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 2000);
        chk({name, "_done"}, done, 1'b1);
        chk({name, "_drained"}, expW.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            runCycles = 0;
            prevDone = 1'b0;
        end else begin
            if (busy) runCycles++;
            if (regWriteEn) begin
                chk("wen_busy", busy, 1'b1);
                if (expW.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got write to r%0d expected none", regWriteAddr);
                end else begin
                    gotW = expW.pop_front();
                    chk("wr_addr", regWriteAddr, gotW.addr);
                    chk("wr_aluop", aluOp, gotW.op);
                    chk("wr_immsel", immSelect, gotW.imm);
                    chk("wr_imm", immediate, gotW.val);
                end
            end
            if (done && !prevDone) begin
                if (expF.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected busy/idle");
                end else begin
                    gotF = expF.pop_front();
                    chk("fin_address", address, gotF.addr);
                    chk("fin_count", instrCount, gotF.cnt);
                    chk("fin_illegal", illegalOp, gotF.ill);
                    chk("fin_overrun", overrun, gotF.ovr);
                    chk("fin_cycles", runCycles, gotF.cycles);
                    chk("fin_progsel", programSelect, gotF.sel);
                    chk("fin_busy", busy, 1'b0);
                end
                runCycles = 0;
            end
            prevDone = done;
        end
    end

    initial begin
        logic [31:0] rnd;
        logic [3:0]  op;
        int          n;
        logic [1:0]  sel;
        for (int p = 0; p < 4; p++)
            for (int i = 0; i < 128; i++) mem[p][i] = 16'h0000;
        mem[2][0] = 16'h0102; mem[2][1] = 16'h4F12; mem[2][2] = 16'h0203;
        mem[2][3] = 16'h7F12; mem[2][4] = 16'h5F10; mem[2][5] = 16'hE000;
        mem[3][0] = 16'h0111; mem[3][1] = 16'h0222; mem[3][2] = 16'h2312;
        mem[3][3] = 16'h6412; mem[3][4] = 16'h7512; mem[3][5] = 16'hB612;
        mem[3][6] = 16'h8712; mem[3][7] = 16'h5812; mem[3][8] = 16'h4F12;
        mem[3][9] = 16'hE000;
        mem[1][0] = 16'hF123; mem[1][1] = 16'hE000;

        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_address", address, 8'd0);
        chk("rst_count", instrCount, 8'd0);
        chk("rst_wen", regWriteEn, 1'b0);
        chk("rst_flags", {illegalOp, overrun, immSelect}, 3'b000);
        chk("rst_progsel", programSelect, 2'b00);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 1'b0);

        launch(2'b10, 1'b0);
        waitDone("prog2");
        launch(2'b11, 1'b0);
        waitDone("prog3");
        launch(2'b01, 1'b0);
        waitDone("prog1");
        launch(2'b00, 1'b0);
        waitDone("prog0");
        repeat (5) @(negedge clk);
        chk("ovr_hold_addr", address, 8'd127);
        chk("ovr_hold_done", done, 1'b1);
        chk("ovr_hold_busy", busy, 1'b0);

        launch(2'b11, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(regWriteEn && address == 8'd2) && n < 100);
        chk("mid_reached", regWriteEn, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_busy", busy, 1'b0);
        chk("mid_address", address, 8'd0);
        chk("mid_wen", regWriteEn, 1'b0);
        chk("mid_count", instrCount, 8'd0);
        chk("mid_done", done, 1'b0);
        expW.delete();
        expF.delete();
        reset = 1'b0;
        @(negedge clk);

        launch(2'b11, 1'b1);
        waitDone("hold3");
        launch(2'b10, 1'b1);
        waitDone("hold2");
        start = 1'b0;
        @(negedge clk);

        for (int r = 0; r < 8; r++) begin
            sel = 2'($urandom_range(0, 3));
            for (int i = 0; i < 128; i++) begin
                rnd = $urandom;
                op = ($urandom_range(0, 24) == 0) ? 4'hE : 4'($urandom_range(0, 15));
                mem[sel][i] = {op, rnd[11:0]};
            end
            launch(sel, 1'b0);
            waitDone("rand");
        end

        repeat (3) @(negedge clk);
        chk("end_queues", expF.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 16-bit, 16-register CPU.
- Drives the instruction memory address and program select, and latches the returned instruction.
- Decodes the instruction into register-file read/write controls and ALU operation selects.
- Runs from start until a HALT opcode or end of memory, then reports done.

Parameters:
- ADDR_W, 8, instruction address width (PC width).
- MEM_DEPTH, 128, number of valid instruction words per program; highest legal PC = MEM_DEPTH-1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin execution; sampled only in IDLE or HALTED.
- programSel  in  2  program to run; latched when start is accepted.
- instruction  in  16  instruction word from memory (combinational read of address).
- address  out  ADDR_W  current PC to instruction memory.
- programSelect  out  2  latched program select to instruction memory.
- regReadA  out  4  register-file read port A index.
- regReadB  out  4  register-file read port B index.
- regWriteEn  out  1  one-cycle write strobe.
- regWriteAddr  out  4  destination register.
- aluOp  out  4  opcode forwarded to the ALU.
- immSelect  out  1  1 = write data comes from immediate, not ALU.
- immediate  out  8  IR[7:0].
- busy  out  1  high from FETCH through EXECUTE.
- done  out  1  level, high in HALTED.
- illegalOp  out  1  sticky; an unknown opcode was seen in the current run.
- overrun  out  1  sticky; PC ran past MEM_DEPTH-1 without a HALT.
- instrCount  out  8  retired non-halt instructions in the current run, saturating at 255.

Behaviour:
- Instruction fields: IR[15:12] opcode, IR[11:8] dest, IR[7:4] srcA, IR[3:0] srcB, IR[7:0] imm.
- Opcodes: 0000 SETC, 0010 COPY, 0100 ADD, 0101 NEG, 0110 AND, 0111 OR, 1000 SHL1, 1011 GT, 1110 HALT. All other opcodes are illegal.
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED.
- Reset (any state, including mid-run):
  - State goes to IDLE.
  - PC=0, IR=0, programSelect=0, instrCount=0.
  - All strobes and flags are 0.
- IDLE or HALTED with start=1:
  - Latch programSel.
  - Clear PC, instrCount, illegalOp and overrun.
  - Go to FETCH.
- start is ignored while busy.
- FETCH: address=PC. IR <= instruction at the end of the cycle. Go to DECODE.
- DECODE:
  - regReadA=IR[7:4] and regReadB=IR[3:0] are valid here and held through EXECUTE.
  - If opcode=HALT, go to HALTED. PC stays pointing at the HALT; instrCount is not incremented.
  - Otherwise go to EXECUTE.
- EXECUTE:
  - Legal opcode: regWriteEn=1 for exactly this cycle, regWriteAddr=IR[11:8], aluOp=IR[15:12].
  - immSelect=1 only for SETC.
  - Illegal opcode: no write; set illegalOp; execution continues as a NOP.
  - instrCount += 1, saturating.
  - If PC=MEM_DEPTH-1: set overrun and go to HALTED. Otherwise PC <= PC+1 and go to FETCH.
- Timing: 3 cycles per retired instruction; HALT costs 2 cycles (FETCH, DECODE).
- done rises on the edge that enters HALTED.
- busy=0 in IDLE and HALTED.
- regWriteEn is never asserted outside EXECUTE.
- Outputs are held at their last values in HALTED, except regWriteEn=0.
- start asserted on the same edge as reset: reset wins.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode localparams (OP_SETC … OP_HALT);
  - the state encoding;
  - field bit positions;
  - the isLegalOpcode function.
- Sub-module instruction_decoder: combinational, opcode -> {legal, writesReg, immSelect, isHalt}. The sequencer instantiates it on IR.

Test Plan:
- Reset mid-EXECUTE of instruction 3 -> next cycle state IDLE, address=0, regWriteEn=0, instrCount=0, done=0.
- programSel=2'b10, start pulse:
  - regWriteEn pulses 5 times with regWriteAddr 1,15,2,15,15.
  - immSelect=1 on pulses 1 and 3; immediate 2 then 3.
  - done rises 17 cycles after start is sampled; address=5; instrCount=5.
- programSel=2'b11:
  - regWriteAddr sequence 1,2,3,4,5,6,7,8,15.
  - aluOp sequence 0000,0000,0010,0110,0111,1011,1000,0101,0100.
  - done after 29 cycles; instrCount=9; illegalOp=0.
- Memory model returns 16'hF123 at PC 0, then HALT -> no write for PC 0, illegalOp=1, instrCount=1, done at cycle 5.
- Memory returns all-zero SETC words (never HALT) -> overrun=1 after PC 127 executes, instrCount=128, done=1, no further fetches.
- start held high throughout a run -> no restart until HALTED. In HALTED, start re-latches the new programSel, clears the flags, and restarts at address 0.
